mastermind_feedback_ctrl: RTL and testbench
===========================================

# mastermind_feedback_ctrl

Round controller for the Mastermind game. It latches a 4-peg secret and a 4-peg guess, each peg a 2-bit colour, and scores the guess by exact-position matches. It then sequences the shared 3x8 LED decoder (`decod3x8`, inputs `modo`/`s1`/`s0`), showing per-peg feedback one peg at a time. It also tracks the attempt count and win/lose status.

## Interface
- `DWELL`, default 4: cycles each peg's feedback is held on the decoder; legal range 1..256.
- `MAX_TRIES`, default 8: guesses allowed per secret; legal range 1..15.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `secret_load`  in  1  one-cycle strobe; latch `secret`, start a new game.
- `secret`  in  8  peg p = `secret[2p+1:2p]`, p = 0..3.
- `guess_valid`  in  1  one-cycle strobe; submit `guess` (accepted only in READY).
- `guess`  in  8  same packing as `secret`.
- `modo`  out  1  decoder bank select; 1 = exact match, 0 = miss.
- `s1`  out  1  decoder select bit 1, equal to peg index bit 1.
- `s0`  out  1  decoder select bit 0, equal to peg index bit 0.
- `dec_en`  out  1  decoder outputs meaningful; LED gating qualifier.
- `busy`  out  1  high in SHOW.
- `hits`  out  3  exact matches of last accepted guess, 0..4.
- `tries`  out  4  guesses accepted since last `secret_load`.
- `win`  out  1  game won; sticky until `secret_load` or reset.
- `lose`  out  1  tries exhausted without win; sticky until `secret_load` or reset.

## Operation
- All outputs are registered.
- States:
  - IDLE: no secret loaded.
  - READY: waiting for a guess.
  - SHOW: displaying feedback.
  - WIN, LOSE: terminal states.
- Reset (`rst_n`=0 at an edge) forces:
  - state IDLE;
  - `modo`=`s1`=`s0`=`dec_en`=`busy`=`win`=`lose`=0;
  - `hits`=0, `tries`=0;
  - peg index and dwell counter cleared.
- `secret_load` in any state:
  - latch secret; clear `tries`, `hits`, `win`, `lose`, `dec_en`;
  - go to READY.
  - In SHOW this aborts the display immediately.
- `guess_valid` in READY:
  - latch guess;
  - match[p] = (guess peg p == secret peg p);
  - `hits` = popcount(match);
  - `tries` += 1;
  - go to SHOW with peg=0 and dwell=0.
- `guess_valid` in IDLE, SHOW, WIN or LOSE is ignored; no state change.
- SHOW behaviour:
  - `dec_en`=1, `busy`=1, {`s1`,`s0`}=peg, `modo`=match[peg].
  - Decoder line l{modo,s1,s0} lights: l4..l7 show hits on pegs 0..3, l0..l3 show misses.
  - Dwell counts 0..DWELL-1, then peg advances.
- After the last cycle of peg 3, transition in this priority order:
  - `hits`==4 → WIN.
  - else `tries`==MAX_TRIES → LOSE.
  - else → READY.
- On leaving SHOW: `dec_en`=0, `busy`=0, `modo`/`s1`/`s0` return to 0.
- WIN/LOSE: `win`/`lose`=1; only `secret_load` or reset exits.
- Simultaneous `secret_load` and `guess_valid`: `secret_load` wins; the guess is dropped and `tries` is not incremented.
- Reset asserted together with any strobe: reset wins.

## Timing
- `guess_valid` sampled at edge k:
  - `hits`, `tries`, `busy`=1, `dec_en`=1 and peg-0 selects are visible after edge k.
  - Peg p is displayed after edges k+p·DWELL .. k+(p+1)·DWELL−1.
- SHOW lasts exactly 4·DWELL cycles.
- State after edge k+4·DWELL is READY, WIN or LOSE; `win`/`lose` are visible from that edge.
- READY accepts a new guess at the first edge after SHOW exits. There is no back-to-back acceptance during SHOW.
- `secret_load` at edge k: READY with cleared status visible after edge k.
- `tries` never wraps: no guess is accepted once LOSE or WIN is reached.
- `hits` holds its value through READY until the next accepted guess.

## Test plan
- Reset, then `guess_valid` with no secret loaded → stays IDLE; `tries`=0; `dec_en`=0.
- Secret 8'b11_10_01_00, guess 8'b11_00_01_10, DWELL=4:
  - `hits`=2, `tries`=1.
  - Selects peg0/modo0, peg1/modo1, peg2/modo0, peg3/modo1, each for exactly 4 cycles.
  - Then READY.
- Guess equal to secret → `hits`=4; after 16 SHOW cycles `win`=1. A later `guess_valid` is ignored and `tries` is unchanged.
- 8 wrong guesses (MAX_TRIES=8) → `lose`=1 after the 8th SHOW. `tries`=8 stays there; a 9th guess is ignored.
- `guess_valid` during SHOW is ignored (`tries` unchanged). `secret_load` mid-SHOW → next cycle READY, `dec_en`=0, `tries`=0.
- Same-cycle `secret_load` and `guess_valid` in READY → READY, `tries`=0. `rst_n`=0 mid-SHOW → all outputs 0 next cycle.

Source files
------------

// File: rtl/mastermind_feedback_ctrl_if.sv
// rtl/mastermind_feedback_ctrl_if.sv - strobe/data and decoder/status bundle for the Mastermind round controller
interface mastermind_feedback_ctrl_if;
    logic       secret_load;
    logic [7:0] secret;
    logic       guess_valid;
    logic [7:0] guess;
    logic       modo;
    logic       s1;
    logic       s0;
    logic       dec_en;
    logic       busy;
    logic [2:0] hits;
    logic [3:0] tries;
    logic       win;
    logic       lose;

    modport master (
        output secret_load, secret, guess_valid, guess,
        input  modo, s1, s0, dec_en, busy, hits, tries, win, lose
    );

    modport slave (
        input  secret_load, secret, guess_valid, guess,
        output modo, s1, s0, dec_en, busy, hits, tries, win, lose
    );
endinterface

// File: rtl/mastermind_feedback_ctrl.sv
// rtl/mastermind_feedback_ctrl.sv - Mastermind round controller: scores guesses and sequences per-peg LED feedback
module mastermind_feedback_ctrl #(
    parameter int DWELL     = 4,
    parameter int MAX_TRIES = 8
) (
    input logic                      clk,
    input logic                      rst_n,
    mastermind_feedback_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        SHOW  = 3'd2,
        WIN   = 3'd3,
        LOSE  = 3'd4
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
    localparam logic [3:0] TRIES_MAX  = 4'(MAX_TRIES);

    state_t     state_q, state_n;
    logic [7:0] secret_q, secret_n;
    logic [3:0] match_q, match_n;
    logic [1:0] peg_q, peg_n;
    logic [7:0] dwell_q, dwell_n;
    logic [2:0] hits_q, hits_n;
    logic [3:0] tries_q, tries_n;
    logic       win_q, win_n;
    logic       lose_q, lose_n;
    logic       modo_q, modo_n;
    logic [1:0] sel_q, sel_n;
    logic       dec_en_q, dec_en_n;
    logic       busy_q, busy_n;

    logic [3:0] guess_match;
    logic [1:0] peg_next;

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            guess_match[p] = (bus.guess[2*p +: 2] == secret_q[2*p +: 2]);
        end
    end

    assign peg_next = peg_q + 2'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            secret_q <= '0;
            match_q  <= '0;
            peg_q    <= '0;
            dwell_q  <= '0;
            hits_q   <= '0;
            tries_q  <= '0;
            win_q    <= 1'b0;
            lose_q   <= 1'b0;
            modo_q   <= 1'b0;
            sel_q    <= '0;
            dec_en_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            secret_q <= secret_n;
            match_q  <= match_n;
            peg_q    <= peg_n;
            dwell_q  <= dwell_n;
            hits_q   <= hits_n;
            tries_q  <= tries_n;
            win_q    <= win_n;
            lose_q   <= lose_n;
            modo_q   <= modo_n;
            sel_q    <= sel_n;
            dec_en_q <= dec_en_n;
            busy_q   <= busy_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        secret_n = secret_q;
        match_n  = match_q;
        peg_n    = peg_q;
        dwell_n  = dwell_q;
        hits_n   = hits_q;
        tries_n  = tries_q;
        win_n    = win_q;
        lose_n   = lose_q;
        modo_n   = modo_q;
        sel_n    = sel_q;
        dec_en_n = dec_en_q;
        busy_n   = busy_q;

        // A new secret overrides everything, including a coincident guess.
        if (bus.secret_load) begin
            state_n  = READY;
            secret_n = bus.secret;
            peg_n    = '0;
            dwell_n  = '0;
            hits_n   = '0;
            tries_n  = '0;
            win_n    = 1'b0;
            lose_n   = 1'b0;
            modo_n   = 1'b0;
            sel_n    = '0;
            dec_en_n = 1'b0;
            busy_n   = 1'b0;
        end else begin
            case (state_q)
                READY: begin
                    if (bus.guess_valid) begin
                        state_n  = SHOW;
                        match_n  = guess_match;
                        hits_n   = 3'(guess_match[0]) + 3'(guess_match[1])
                                 + 3'(guess_match[2]) + 3'(guess_match[3]);
                        tries_n  = tries_q + 4'd1;
                        peg_n    = '0;
                        dwell_n  = '0;
                        sel_n    = '0;
                        modo_n   = guess_match[0];
                        dec_en_n = 1'b1;
                        busy_n   = 1'b1;
                    end
                end
                SHOW: begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_n = '0;
                        if (peg_q == 2'd3) begin
                            peg_n    = '0;
                            sel_n    = '0;
                            modo_n   = 1'b0;
                            dec_en_n = 1'b0;
                            busy_n   = 1'b0;
                            if (hits_q == 3'd4) begin
                                state_n = WIN;
                                win_n   = 1'b1;
                            end else if (tries_q == TRIES_MAX) begin
                                state_n = LOSE;
                                lose_n  = 1'b1;
                            end else begin
                                state_n = READY;
                            end
                        end else begin
                            peg_n  = peg_next;
                            sel_n  = peg_next;
                            modo_n = match_q[peg_next];
                        end
                    end else begin
                        dwell_n = dwell_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.modo   = modo_q;
    assign bus.s1     = sel_q[1];
    assign bus.s0     = sel_q[0];
    assign bus.dec_en = dec_en_q;
    assign bus.busy   = busy_q;
    assign bus.hits   = hits_q;
    assign bus.tries  = tries_q;
    assign bus.win    = win_q;
    assign bus.lose   = lose_q;
endmodule

// File: tb/tb_mastermind_feedback_ctrl.sv
// tb/tb_mastermind_feedback_ctrl.sv - directed scoreboard bench for mastermind_feedback_ctrl
module tb_mastermind_feedback_ctrl;
    localparam int DWELL     = 4;
    localparam int MAX_TRIES = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    logic [7:0] sec_model;
    int         tries_model;
    logic [4:0] disp_q[$];

    mastermind_feedback_ctrl_if bus ();

    mastermind_feedback_ctrl #(.DWELL(DWELL), .MAX_TRIES(MAX_TRIES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] disp();
        return {bus.dec_en, bus.busy, bus.modo, bus.s1, bus.s0};
    endfunction

    task automatic load(input logic [7:0] s);
        bus.secret = s;
        bus.secret_load = 1'b1;
        tick();
        bus.secret_load = 1'b0;
        sec_model = s;
        tries_model = 0;
        chk("load_tries", 32'(bus.tries), 32'd0);
        chk("load_disp", 32'(disp()), 32'd0);
    endtask

    // Accepts a guess, walks the whole display against the scoreboard, checks the exit outcome.
    task automatic submit(input logic [7:0] g);
        logic [3:0] m;
        int         h;
        logic [4:0] e;
        h = 0;
        for (int p = 0; p < 4; p++) begin
            m[p] = (g[2*p +: 2] == sec_model[2*p +: 2]);
            if (m[p]) h++;
        end
        for (int p = 0; p < 4; p++) begin
            for (int d = 0; d < DWELL; d++) begin
                disp_q.push_back({1'b1, 1'b1, m[p], 2'(p)});
            end
        end
        tries_model++;
        bus.guess = g;
        bus.guess_valid = 1'b1;
        tick();
        bus.guess_valid = 1'b0;
        chk("hits", 32'(bus.hits), 32'(h));
        chk("tries", 32'(bus.tries), 32'(tries_model));
        while (disp_q.size() > 0) begin
            e = disp_q.pop_front();
            chk("show", 32'(disp()), 32'(e));
            tick();
        end
        chk("exit_disp", 32'(disp()), 32'd0);
        chk("win", 32'(bus.win), 32'(h == 4));
        chk("lose", 32'(bus.lose), 32'((h != 4) && (tries_model == MAX_TRIES)));
    endtask

    initial begin
        logic [7:0] wrong[8];
        wrong[0] = 8'hFF; wrong[1] = 8'hFC; wrong[2] = 8'hF0; wrong[3] = 8'hC0;
        wrong[4] = 8'h55; wrong[5] = 8'hAA; wrong[6] = 8'h03; wrong[7] = 8'h0C;

        bus.secret_load = 1'b0;
        bus.secret = 8'h00;
        bus.guess_valid = 1'b0;
        bus.guess = 8'h00;
        sec_model = 8'h00;
        tries_model = 0;
        rst_n = 1'b0;
        tick();
        tick();
        chk("reset_disp", 32'(disp()), 32'd0);
        chk("reset_status", {25'd0, bus.hits, bus.tries}, 32'd0);
        chk("reset_winlose", {30'd0, bus.win, bus.lose}, 32'd0);
        rst_n = 1'b1;

        bus.guess_valid = 1'b1;
        tick();
        bus.guess_valid = 1'b0;
        chk("idle_guess_tries", 32'(bus.tries), 32'd0);
        chk("idle_guess_disp", 32'(disp()), 32'd0);

        load(8'b11_10_01_00);
        submit(8'b11_00_01_10);
        chk("example_hits", 32'(bus.hits), 32'd2);
        tick();
        chk("hits_hold", 32'(bus.hits), 32'd2);

        bus.guess = 8'h00;
        bus.guess_valid = 1'b1;
        tick();
        bus.guess_valid = 1'b1;
        tick();
        tick();
        bus.guess_valid = 1'b0;
        chk("show_guess_ignored", 32'(bus.tries), 32'd2);
        chk("show_busy", 32'(bus.busy), 32'd1);
        load(8'b00_01_10_11);
        chk("abort_hits", 32'(bus.hits), 32'd0);
        submit(8'b00_01_10_00);

        bus.guess = 8'h00;
        bus.guess_valid = 1'b1;
        bus.secret = 8'h1B;
        bus.secret_load = 1'b1;
        tick();
        bus.secret_load = 1'b0;
        bus.guess_valid = 1'b0;
        sec_model = 8'h1B;
        tries_model = 0;
        chk("both_tries", 32'(bus.tries), 32'd0);
        chk("both_busy", 32'(bus.busy), 32'd0);

        submit(8'h1B);
        bus.guess_valid = 1'b1;
        tick();
        bus.guess_valid = 1'b0;
        chk("win_guess_ignored", 32'(bus.tries), 32'd1);
        chk("win_sticky", 32'(bus.win), 32'd1);
        chk("win_idle_disp", 32'(disp()), 32'd0);

        load(8'h00);
        chk("load_clears_win", 32'(bus.win), 32'd0);
        for (int i = 0; i < MAX_TRIES; i++) begin
            submit(wrong[i]);
            tick();
        end
        bus.guess = 8'h00;
        bus.guess_valid = 1'b1;
        tick();
        bus.guess_valid = 1'b0;
        chk("lose_tries_hold", 32'(bus.tries), 32'(MAX_TRIES));
        chk("lose_sticky", 32'(bus.lose), 32'd1);
        chk("lose_busy", 32'(bus.busy), 32'd0);

        load(8'hE4);
        bus.guess = 8'hE4;
        bus.guess_valid = 1'b1;
        tick();
        bus.guess_valid = 1'b0;
        tick();
        chk("pre_reset_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        bus.secret_load = 1'b1;
        tick();
        bus.secret_load = 1'b0;
        rst_n = 1'b1;
        chk("midshow_reset_disp", 32'(disp()), 32'd0);
        chk("midshow_reset_status", {25'd0, bus.hits, bus.tries}, 32'd0);
        bus.guess_valid = 1'b1;
        tick();
        bus.guess_valid = 1'b0;
        chk("post_reset_idle", 32'(bus.tries), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
